// File: rtl/alu_multicycle.sv
// Execution-stage ALU: registered single-cycle ops plus an iterative shift-add multiplier.
// Optional build macro ALU_MULHI_EN adds result_hi_o with the upper half of the MUL product.
module alu_multicycle #(
   parameter int WIDTH   = 24,
   parameter int SHAMT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [3:0]       operation_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             done_o
`ifdef ALU_MULHI_EN
   ,
   output logic [WIDTH-1:0] result_hi_o
`endif
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0100;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [SHAMT_W:0] SH_LIMIT = (SHAMT_W + 1)'(WIDTH);

   // With the high half enabled the accumulator keeps the full double-width product.
`ifdef ALU_MULHI_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ACC_W-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [ACC_W-1:0] acc_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             ovf_q;
   logic             done_q;
`ifdef ALU_MULHI_EN
   logic [WIDTH-1:0] resultHi_q;
`endif

   logic             accept;
   logic             mulLast;
   logic [WIDTH-1:0] aluRes;
   logic             aluOvf;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SHAMT_W-1:0] shamt;
   logic [ACC_W-1:0] accNext;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && (operation_i == OP_MUL)) begin
               state_d = S_MUL;
               count_d = '0;
            end
         end
         S_MUL: begin
            if (count_q == LAST_CNT) begin
               state_d = S_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state_q == S_MUL);
      accept  = (state_q == S_IDLE) && start_i;
      mulLast = (state_q == S_MUL) && (count_q == LAST_CNT);
   end

   // Single-cycle results come straight from the live operands, since they retire on the accepting edge.
   always_comb begin
      aluRes = '0;
      aluOvf = 1'b0;
      sum    = a_i + b_i;
      diff   = a_i - b_i;
      shamt  = b_i[SHAMT_W-1:0];
      case (operation_i)
         OP_AND: aluRes = a_i & b_i;
         OP_OR:  aluRes = a_i | b_i;
         OP_XOR: aluRes = a_i ^ b_i;
         OP_ADD: begin
            aluRes = sum;
            aluOvf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            aluRes = diff;
            aluOvf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SLT: aluRes = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLL: aluRes = ({1'b0, shamt} >= SH_LIMIT) ? '0 : (a_i << shamt);
         default: begin
            aluRes = '0;
            aluOvf = 1'b0;
         end
      endcase
   end

   always_comb begin
      accNext = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Result and flags only move on a completion; everything else holds.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef ALU_MULHI_EN
         resultHi_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            if (operation_i == OP_MUL) begin
               mcand_q  <= ACC_W'(a_i);
               mplier_q <= b_i;
               acc_q    <= '0;
            end else begin
               result_q <= aluRes;
               zero_q   <= (aluRes == '0);
               ovf_q    <= aluOvf;
               done_q   <= 1'b1;
            end
         end else if (state_q == S_MUL) begin
            acc_q    <= accNext;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (mulLast) begin
               result_q <= accNext[WIDTH-1:0];
               zero_q   <= (accNext[WIDTH-1:0] == '0);
               ovf_q    <= 1'b0;
               done_q   <= 1'b1;
`ifdef ALU_MULHI_EN
               resultHi_q <= accNext[ACC_W-1:WIDTH];
`endif
            end
         end
      end
   end

   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign overflow_o = ovf_q;
   assign done_o     = done_q;
`ifdef ALU_MULHI_EN
   assign result_hi_o = resultHi_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle; also checks result_hi_o when ALU_MULHI_EN is defined.
module tb_alu_multicycle;

   localparam int W = 24;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0100;

   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   op = 4'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] resultO;
   logic         zeroO;
   logic         overflowO;
   logic         busyO;
   logic         doneO;
`ifdef ALU_MULHI_EN
   logic [W-1:0] resultHiO;
`endif

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
      logic         ovf;
      logic [W-1:0] hi;
   } exp_t;

   exp_t         sbQ[$];
   logic [W-1:0] modelHi = '0;
   logic [W-1:0] lastRes = '0;
   logic [W-1:0] holdRes = '0;
   int           checks = 0;
   int           errors = 0;

   alu_multicycle #(.WIDTH(W), .SHAMT_W(5)) dut (
      .clk_i      (clk),
      .rst_ni     (rstN),
      .start_i    (start),
      .operation_i(op),
      .a_i        (a),
      .b_i        (b),
      .result_o   (resultO),
      .zero_o     (zeroO),
      .overflow_o (overflowO),
      .busy_o     (busyO),
      .done_o     (doneO)
`ifdef ALU_MULHI_EN
      ,
      .result_hi_o(resultHiO)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: signed overflow judged from a one-bit-wider sum rather than sign rules.
   function automatic exp_t modelAlu(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] hiPrev);
      exp_t           e;
      logic [2*W-1:0] prod;
      logic signed [W:0] wide;
      e.res = '0;
      e.ovf = 1'b0;
      e.hi  = hiPrev;
      case (o)
         OP_AND: e.res = x & y;
         OP_OR:  e.res = x | y;
         OP_XOR: e.res = x ^ y;
         OP_ADD: begin
            wide  = $signed({x[W-1], x}) + $signed({y[W-1], y});
            e.res = wide[W-1:0];
            e.ovf = wide[W] != wide[W-1];
         end
         OP_SUB: begin
            wide  = $signed({x[W-1], x}) - $signed({y[W-1], y});
            e.res = wide[W-1:0];
            e.ovf = wide[W] != wide[W-1];
         end
         OP_SLT: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
         OP_SLL: e.res = (int'(y[4:0]) >= W) ? '0 : (x << y[4:0]);
         OP_MUL: begin
            prod  = (2*W)'(x) * (2*W)'(y);
            e.res = prod[W-1:0];
            e.hi  = prod[2*W-1:W];
         end
         default: e.res = '0;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one request at the current negedge and keeps Start high across exactly one rising edge.
   task automatic applyStimulus(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y);
      exp_t e;
      e = modelAlu(o, x, y, modelHi);
      sbQ.push_back(e);
      holdRes = lastRes;
      lastRes = e.res;
      modelHi = e.hi;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic awaitDone(string tag, int expWait, int pokeAt, bit checkFall);
      int   waited = 0;
      int   busyCnt = 0;
      int   holdBad = 0;
      exp_t e;
      while (!doneO && waited < 100) begin
         if (busyO) busyCnt++;
         if (resultO !== holdRes) holdBad++;
         if (waited == pokeAt) begin
            start = 1'b1;
            op    = OP_ADD;
            a     = 24'h000111;
            b     = 24'h000222;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         waited++;
      end
      start = 1'b0;
      checkOutput({tag, " latency"}, 32'(waited), 32'(expWait));
      checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'(expWait));
      checkOutput({tag, " holdWhileBusy"}, 32'(holdBad), 32'd0);
      checkOutput({tag, " busyAtDone"}, 32'(busyO), 32'd0);
      if (sbQ.size() == 0) begin
         checkOutput({tag, " scoreboardEmpty"}, 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkOutput({tag, " result"}, 32'(resultO), 32'(e.res));
         checkOutput({tag, " zero"}, 32'(zeroO), 32'(e.zero));
         checkOutput({tag, " overflow"}, 32'(overflowO), 32'(e.ovf));
`ifdef ALU_MULHI_EN
         checkOutput({tag, " resultHi"}, 32'(resultHiO), 32'(e.hi));
`endif
      end
      if (checkFall) begin
         @(negedge clk);
         checkOutput({tag, " donePulse"}, 32'(doneO), 32'd0);
      end
   endtask

   function automatic int latencyOf(logic [3:0] o);
      return (o == OP_MUL) ? W : 0;
   endfunction

   initial begin
      logic [3:0] opsList[8];
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      int doneSeen;
      opsList = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_SLL, OP_MUL};

      repeat (2) @(negedge clk);
      checkOutput("reset result", 32'(resultO), 32'd0);
      checkOutput("reset zero", 32'(zeroO), 32'd1);
      checkOutput("reset overflow", 32'(overflowO), 32'd0);
      checkOutput("reset busy", 32'(busyO), 32'd0);
      checkOutput("reset done", 32'(doneO), 32'd0);
      rstN = 1'b1;
      @(negedge clk);

      applyStimulus(OP_ADD, 24'h7FFFFF, 24'h000001);
      awaitDone("add_ovf", 0, -1, 1'b1);
      applyStimulus(OP_SUB, 24'h000005, 24'h000005);
      awaitDone("sub_zero", 0, -1, 1'b1);
      applyStimulus(OP_SLT, 24'hFFFFFF, 24'h000001);
      awaitDone("slt_neg", 0, -1, 1'b1);
      applyStimulus(OP_SUB, 24'h800000, 24'h000001);
      awaitDone("sub_ovf", 0, -1, 1'b1);

      applyStimulus(OP_MUL, 24'h000123, 24'h000456);
      awaitDone("mul_poke", W, 7, 1'b1);
      applyStimulus(OP_MUL, 24'h800000, 24'h000004);
      awaitDone("mul_hi", W, -1, 1'b1);

      applyStimulus(OP_SLL, 24'h000001, 24'h000017);
      awaitDone("sll_23", 0, -1, 1'b1);
      applyStimulus(OP_SLL, 24'h000001, 24'h000018);
      awaitDone("sll_24", 0, -1, 1'b1);
      applyStimulus(4'b1111, 24'h123456, 24'h654321);
      awaitDone("illegal_op", 0, -1, 1'b1);

      // Back-to-back: the next request is driven while Done is still high.
      applyStimulus(OP_AND, 24'hF0F0F0, 24'h0FF00F);
      awaitDone("b2b_and", 0, -1, 1'b0);
      applyStimulus(OP_OR, 24'h00000F, 24'h0000F0);
      awaitDone("b2b_or", 0, -1, 1'b0);
      applyStimulus(OP_MUL, 24'h000003, 24'h000005);
      awaitDone("b2b_mul", W, -1, 1'b0);
      applyStimulus(OP_XOR, 24'hAAAAAA, 24'hAAAAAA);
      awaitDone("b2b_xor", 0, -1, 1'b1);

      // Abort a multiply with a single reset edge partway through.
      applyStimulus(OP_MUL, 24'h000123, 24'h000456);
      repeat (9) @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("abort busy", 32'(busyO), 32'd0);
      checkOutput("abort done", 32'(doneO), 32'd0);
      checkOutput("abort result", 32'(resultO), 32'd0);
      checkOutput("abort zero", 32'(zeroO), 32'd1);
      rstN = 1'b1;
      sbQ.delete();
      lastRes = '0;
      modelHi = '0;
      applyStimulus(OP_ADD, 24'h000002, 24'h000003);
      awaitDone("add_after_abort", 0, -1, 1'b1);
      doneSeen = 0;
      repeat (W + 4) begin
         @(negedge clk);
         if (doneO) doneSeen++;
      end
      checkOutput("no_late_mul_done", 32'(doneSeen), 32'd0);

      for (int i = 0; i < 8; i++) begin
         ro = opsList[$urandom_range(0, 7)];
         ra = W'($urandom);
         rb = W'($urandom);
         applyStimulus(ro, ra, rb);
         awaitDone($sformatf("rand%0d_op%b", i, ro), latencyOf(ro), -1, 1'b1);
      end

      checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Execution-stage ALU for the 24-bit CPU. It consumes the 4-bit Operation code produced by the ALU control decoder, together with operands A and B.
- Single-cycle ops return a registered result one cycle after Start.
- MUL runs as an iterative shift-add multiplier, with a Busy output for pipeline stall.
- Flags (Zero, Overflow) feed branch resolution (BEQ/BNE via SUB) and hazard logic.

Parameters:
WIDTH, 24, datapath width of A, B, Result
SHAMT_W, 5, shift-amount bits taken from B[SHAMT_W-1:0] for SLL

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
Start  input  1  request; sampled only when idle
Operation  input  4  ALU operation code
A  input  WIDTH  operand A
B  input  WIDTH  operand B / shift amount
Result  output  WIDTH  registered result
Zero  output  1  registered, Result == 0
Overflow  output  1  registered signed overflow (ADD/SUB only)
Busy  output  1  multiplier in progress; upstream must stall
Done  output  1  one-cycle pulse, Result/flags updated this cycle

Behaviour:
- Reset (Reset=0 at rising edge):
  - state=IDLE; Result=0, Zero=1, Overflow=0, Busy=0, Done=0.
  - Multiplier accumulator and counter are cleared.
  - Reset mid-multiply aborts the operation; no Done is produced.
- States:
  - IDLE: Start=1 is accepted; A, B and Operation are latched.
    - Non-MUL code: go to IDLE (stay).
    - MUL code: go to MUL.
  - MUL: count 0..WIDTH-1, one multiplier bit per cycle; go to IDLE when count==WIDTH-1.
- Operation codes (all arithmetic mod 2^WIDTH):
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 1010 SUB (A-B).
  - 0011 SLT: signed compare; Result=1 if A<B else 0.
  - 0101 XOR.
  - 0110 SLL: A << B[SHAMT_W-1:0]; shift >= WIDTH gives Result=0.
  - 0100 MUL: unsigned, low WIDTH bits of A*B.
  - Any other code: Result=0, Overflow=0; Done still pulses after 1 cycle.
- Single-cycle timing:
  - Start accepted at edge k.
  - At edge k: Result, Zero and Overflow are written and Done=1.
  - After edge k+1: Done=0.
  - Busy stays 0 throughout.
- MUL timing:
  - At edge k: operands are loaded and Busy=1.
  - Edges k+1..k+WIDTH-1 perform the remaining iterations.
  - At edge k+WIDTH: Result is written, Done=1, Busy=0, state=IDLE.
  - Latency is exactly WIDTH cycles.
  - Result keeps its previous value while Busy=1.
- Overflow:
  - ADD: set when the operand signs are equal and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from A.
  - 0 for all other operations.
- Zero: computed from the new Result value and written in the same cycle.
- Start while Busy=1: ignored; no queueing, no effect on the current operation.
- Start in the same cycle Done=1 (state IDLE): accepted normally, giving back-to-back issue.
- Result and flags hold until the next completion.

Optional Feature:
ALU_MULHI_EN
- Defined:
  - Adds output port ResultHi (WIDTH bits) holding the upper WIDTH bits of the unsigned 2*WIDTH product.
  - Written with Result when a MUL completes.
  - Cleared to 0 on reset.
  - Keeps its value across non-MUL operations.
- Undefined:
  - No ResultHi port exists; the product is truncated to WIDTH bits.
  - The accumulator is only WIDTH bits wide.

Test Plan:
- ADD A=0x7FFFFF, B=0x000001, Start pulse -> next edge Result=0x800000, Overflow=1, Zero=0, Done=1 for one cycle, Busy never 1.
- SUB A=0x000005, B=0x000005 -> Result=0x000000, Zero=1, Overflow=0. Then SLT with A=0xFFFFFF, B=0x000001 -> Result=0x000001.
- MUL A=0x000123, B=0x000456 at edge k:
  - Busy=1 for cycles k..k+23.
  - Done at edge k+24 with Result=0x04EDC2.
  - Start pulses issued mid-multiply are ignored.
  - Result holds the prior value until edge k+24.
- MUL A=0x800000, B=0x000004 -> Result=0x000000, Zero=1; with ALU_MULHI_EN, ResultHi=0x000002.
- SLL A=0x000001, B=0x000017 -> Result=0x800000. SLL B=0x000018 -> Result=0. Operation=1111 -> Result=0, Done after 1 cycle.
- Reset=0 held one edge at iteration 10 of a MUL -> Busy=0, Done=0, Result=0, Zero=1. A new ADD 2+3 issued immediately after -> Result=0x000005.
